// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready flow control and a 2-entry skid buffer.
// Both handshake outputs come from flops, so no combinational ready path crosses the stage.
module pipe_skid_stage #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, out_valid_q;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // State register; handshake flags are decoded from the next state so they are registered.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Storage moves: M always holds the oldest beat, S only the one absorbed under backpressure.
    always_comb begin
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (!flush) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (in_fire) begin
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
        end
    end

    // Bubbles carry zero control so downstream sees a harmless no-op.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        out_ctrl  = out_valid_q ? m_ctrl_q : '0;
        out_data  = m_data_q;
        occupancy = state_q;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of pipe_skid_stage against a FIFO scoreboard.
module tb_pipe_skid_stage;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 128;
    localparam int BW     = CTRL_W + DATA_W;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] q[$];

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the scoreboard from the handshakes seen at the edge, then check outputs.
    task automatic step();
        logic inf, outf;
        inf  = !Reset && in_valid && in_ready;
        outf = !Reset && out_valid && out_ready;
        @(posedge CLK);
        if (Reset) begin
            q.delete();
        end else begin
            if (outf && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (inf) q.push_back({in_ctrl, in_data});
        end
        #1;
        chk("occ", 160'(occupancy), 160'(q.size()));
        chk("ovld", 160'(out_valid), 160'(q.size() != 0));
        chk("irdy", 160'(in_ready), 160'(q.size() < 2));
        if (q.size() > 0) chk("head", 160'({out_ctrl, out_data}), 160'(q[0]));
        else              chk("bubble_ctrl", 160'(out_ctrl), 160'(0));
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        Reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 9'h1AA, 128'hDEAD, 1'b1);

        // 1: reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t1_ovld", 160'(out_valid), 160'(0));
            chk("t1_ctrl", 160'(out_ctrl), 160'(0));
            chk("t1_data", 160'(out_data), 160'(0));
            chk("t1_irdy", 160'(in_ready), 160'(1));
            chk("t1_occ", 160'(occupancy), 160'(0));
        end
        $display("t1 reset: occ=%0d in_ready=%0d", occupancy, in_ready);
        Reset = 1'b0;

        // 2: full-throughput stream, one-cycle lag
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 9'(i), 128'(32'h100 + i), 1'b1);
            step();
            chk("t2_ctrl", 160'(out_ctrl), 160'(i));
            chk("t2_data", 160'(out_data), 160'(32'h100 + i));
            chk("t2_occ", 160'(occupancy), 160'(1));
            $display("t2 beat %0d: out_ctrl=%0h out_data=%0h", i, out_ctrl, out_data);
        end
        drive(1'b0, 9'h0, 128'h0, 1'b1);
        step();
        chk("t2_drain_ovld", 160'(out_valid), 160'(0));

        // 3: backpressure fills the skid entry, then drains in order
        drive(1'b1, 9'h05, 128'h555, 1'b0);
        step();
        chk("t3_occ1", 160'(occupancy), 160'(1));
        drive(1'b1, 9'h06, 128'h666, 1'b0);
        step();
        chk("t3_occ2", 160'(occupancy), 160'(2));
        chk("t3_irdy0", 160'(in_ready), 160'(0));
        chk("t3_head5", 160'(out_ctrl), 160'(9'h05));
        drive(1'b0, 9'h0, 128'h0, 1'b1);
        step();
        chk("t3_head6", 160'(out_ctrl), 160'(9'h06));
        chk("t3_irdy1", 160'(in_ready), 160'(1));
        step();
        chk("t3_empty", 160'(occupancy), 160'(0));
        $display("t3 skid: drained, occ=%0d", occupancy);

        // 4: flush at occupancy 2 discards held beats and the concurrent input
        drive(1'b1, 9'h0A, 128'hA, 1'b0);
        step();
        drive(1'b1, 9'h0B, 128'hB, 1'b0);
        step();
        chk("t4_occ2", 160'(occupancy), 160'(2));
        flush = 1'b1;
        drive(1'b1, 9'h1FF, 128'h1FF, 1'b0);
        step();
        flush = 1'b0;
        chk("t4_ovld", 160'(out_valid), 160'(0));
        chk("t4_ctrl", 160'(out_ctrl), 160'(0));
        chk("t4_occ", 160'(occupancy), 160'(0));
        chk("t4_irdy", 160'(in_ready), 160'(1));
        drive(1'b0, 9'h0, 128'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no1ff", 160'(out_valid), 160'(0));
        end
        $display("t4 flush: out_valid=%0d occ=%0d", out_valid, occupancy);

        // 6: reset and flush together at occupancy 1
        drive(1'b1, 9'h33, 128'h3333, 1'b0);
        step();
        chk("t6_occ1", 160'(occupancy), 160'(1));
        Reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 9'h77, 128'h7777, 1'b0);
        step();
        Reset = 1'b0;
        flush = 1'b0;
        chk("t6_data0", 160'(out_data), 160'(0));
        chk("t6_ctrl0", 160'(out_ctrl), 160'(0));
        chk("t6_ovld", 160'(out_valid), 160'(0));
        chk("t6_occ0", 160'(occupancy), 160'(0));
        chk("t6_irdy", 160'(in_ready), 160'(1));
        drive(1'b1, 9'h44, 128'hABC, 1'b1);
        step();
        chk("t6_lat_v", 160'(out_valid), 160'(1));
        chk("t6_lat_c", 160'(out_ctrl), 160'(9'h44));
        chk("t6_lat_d", 160'(out_data), 160'(128'hABC));
        $display("t6 reset+flush: next beat ctrl=%0h data=%0h", out_ctrl, out_data);

        // 5: random handshakes against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 9'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0;
        $display("t5 random: 10000 cycles, final occ=%0d", occupancy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
